ingress_arbiter: RTL and testbench
==================================

// Module: ingress_arbiter
// PURPOSE
//  Shares the single preliminary-processing ingress datapath between NUM_PORTS AXI-Stream frame sources.
//  Round-robin arbitration at frame granularity: a grant is held from first beat to accepted tlast.
//  No new grant is issued while the downstream frame buffer reports almost_full.
//  A stall watchdog aborts a granted frame whose source stops presenting data.
//  Sits between the port MACs and the input FSM of the preliminary processor.
// PARAMETERS
//  NUM_PORTS      4    number of requesting sources (2..8)
//  DATA_W         8    tdata width per beat
//  STALL_TIMEOUT  255  cycles a granted source may hold tvalid low mid-frame before abort (>=1)
// PORTS
//  clk            in   1                  single clock, rising edge
//  reset          in   1                  synchronous, active-low
//  src_tvalid     in   NUM_PORTS          per-source beat valid
//  src_tdata      in   NUM_PORTS*DATA_W   per-source data, port i at [i*DATA_W +: DATA_W]
//  src_tlast      in   NUM_PORTS          per-source end of frame
//  src_tready     out  NUM_PORTS          per-source ready; at most one bit set
//  out_tvalid     out  1                  muxed beat valid to preliminary processor
//  out_tdata      out  DATA_W             muxed data
//  out_tlast      out  1                  muxed end of frame (also set on abort beat)
//  out_tready     in   1                  downstream ready
//  almost_full    in   1                  downstream buffer nearly full; blocks new grants
//  grant_valid    out  1                  a frame grant is active
//  grant_idx      out  $clog2(NUM_PORTS)  index of granted source
//  frame_abort    out  1                  1-cycle pulse: granted frame terminated by watchdog
// BEHAVIOUR
//  Reset (reset==0 at clk edge): state=IDLE; rr_ptr=0; grant_idx=0; grant_valid=0; src_tready=0;
//   out_tvalid=0; out_tlast=0; frame_abort=0; stall_cnt=0. Reset mid-frame drops the frame silently.
//  States: IDLE, BUSY, ABORT.
//  IDLE: outputs idle. If |src_tvalid && !almost_full: winner = first i with src_tvalid[i],
//   searching rr_ptr, rr_ptr+1, ... modulo NUM_PORTS; grant_idx<=winner; grant_valid<=1; ->BUSY.
//   almost_full sampled only in IDLE; it never revokes an active grant.
//  Grant latency: 1 cycle from request in IDLE to first possible transfer in BUSY.
//  BUSY: out_t* = src_t*[grant_idx] (combinational mux); src_tready[grant_idx] = out_tready;
//   all other src_tready = 0. Transfer = out_tvalid && out_tready.
//   Transfer with out_tlast: grant_valid<=0; rr_ptr<=grant_idx+1 (wrap to 0 at NUM_PORTS); ->IDLE.
//   The arbiter never inserts a bubble inside a frame; tready gaps come only from out_tready.
//  Watchdog: in BUSY, stall_cnt increments each cycle the granted src_tvalid==0, clears on any
//   granted src_tvalid==1; counter saturates, never wraps. stall_cnt==STALL_TIMEOUT -> ABORT.
//   Downstream backpressure (valid=1, ready=0) does not count as a stall.
//  ABORT: out_tvalid=1, out_tlast=1, out_tdata=0, all src_tready=0; held until out_tready;
//   on acceptance: frame_abort=1 for that cycle, grant_valid<=0, rr_ptr<=grant_idx+1, ->IDLE.
//   Remaining beats of the aborted source's frame are not removed; that source is not re-granted
//   until its next arbitration turn, and its beats then enter as a new frame.
//  Simultaneous events: tlast transfer on the same cycle the timeout would fire -> normal completion
//   wins. A request appearing in the same cycle as a tlast transfer is arbitrated in the next
//   IDLE cycle (minimum 1 idle cycle between frames).
//  Single requester: it is re-granted each frame; no starvation of any port given finite frames.
// TESTING
//  1. Ports 0 and 2 request, rr_ptr=0: grant_idx=0, then 2; afterwards rr_ptr=3, port 1 requests -> grant 1.
//  2. All 4 ports hold tvalid with 3-beat frames: grants cycle 0,1,2,3,0; each frame takes 3 BUSY + 1 IDLE cycle.
//  3. almost_full=1 in IDLE with port 1 valid: no grant for 10 cycles; deassert -> grant_idx=1 next cycle.
//  4. almost_full rises mid-frame: current frame completes all beats, no further grant afterwards.
//  5. STALL_TIMEOUT=4, granted port drops tvalid after beat 2: abort beat (tlast=1, data=0) after 4 stall cycles, frame_abort pulse.
//  6. reset low during BUSY: next cycle all src_tready=0, grant_valid=0, rr_ptr=0.

Source files
------------

// File: rtl/ingress_arbiter.sv
// Frame-granular round-robin arbiter muxing NUM_PORTS AXI-Stream sources
// onto one ingress stream, with almost_full grant gating and a stall watchdog.
module ingress_arbiter #(
  parameter int NUM_PORTS     = 4,
  parameter int DATA_W        = 8,
  parameter int STALL_TIMEOUT = 255
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_PORTS-1:0]          src_tvalid,
  input  logic [NUM_PORTS*DATA_W-1:0]   src_tdata,
  input  logic [NUM_PORTS-1:0]          src_tlast,
  output logic [NUM_PORTS-1:0]          src_tready,
  output logic                          out_tvalid,
  output logic [DATA_W-1:0]             out_tdata,
  output logic                          out_tlast,
  input  logic                          out_tready,
  input  logic                          almost_full,
  output logic                          grant_valid,
  output logic [$clog2(NUM_PORTS)-1:0]  grant_idx,
  output logic                          frame_abort
);

  localparam int IDX_W = $clog2(NUM_PORTS);
  localparam int CNT_W = $clog2(STALL_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STALL_TIMEOUT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    ABORT = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]   grant_idx_q, grant_idx_d;
  logic               grant_valid_q, grant_valid_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;

  logic               win_found;
  logic [IDX_W-1:0]   win_idx;
  logic               sel_valid;
  logic               sel_last;
  logic [DATA_W-1:0]  sel_data;
  logic [IDX_W-1:0]   nxt_ptr;

  // Two passes: ports at/after rr_ptr first, then wrap from port 0.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (!win_found && src_tvalid[i] &&
          (IDX_W'(i) >= rr_ptr_q)) begin
        win_found = 1'b1;
        win_idx   = IDX_W'(i);
      end
    end
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (!win_found && src_tvalid[i]) begin
        win_found = 1'b1;
        win_idx   = IDX_W'(i);
      end
    end
  end

  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (grant_idx_q == IDX_W'(i)) begin
        sel_valid = src_tvalid[i];
        sel_last  = src_tlast[i];
        sel_data  = src_tdata[i*DATA_W +: DATA_W];
      end
    end
  end

  assign nxt_ptr = (grant_idx_q == IDX_W'(NUM_PORTS - 1)) ?
                   '0 : grant_idx_q + 1'b1;

  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    grant_idx_d   = grant_idx_q;
    grant_valid_d = grant_valid_q;
    stall_cnt_d   = stall_cnt_q;
    src_tready    = '0;
    out_tvalid    = 1'b0;
    out_tdata     = '0;
    out_tlast     = 1'b0;
    frame_abort   = 1'b0;
    unique case (state_q)
      IDLE: begin
        stall_cnt_d = '0;
        if (win_found && !almost_full) begin
          grant_idx_d   = win_idx;
          grant_valid_d = 1'b1;
          state_d       = BUSY;
        end
      end
      BUSY: begin
        out_tvalid = sel_valid;
        out_tdata  = sel_data;
        out_tlast  = sel_last;
        for (int i = 0; i < NUM_PORTS; i++) begin
          src_tready[i] = (grant_idx_q == IDX_W'(i)) && out_tready;
        end
        if (sel_valid) begin
          stall_cnt_d = '0;
        end else if (stall_cnt_q != CNT_MAX) begin
          stall_cnt_d = stall_cnt_q + 1'b1;
        end
        // Completion takes priority over a watchdog firing.
        if (sel_valid && out_tready && sel_last) begin
          grant_valid_d = 1'b0;
          rr_ptr_d      = nxt_ptr;
          state_d       = IDLE;
        end else if (stall_cnt_d == CNT_MAX) begin
          state_d = ABORT;
        end
      end
      ABORT: begin
        out_tvalid = 1'b1;
        out_tlast  = 1'b1;
        if (out_tready) begin
          frame_abort   = 1'b1;
          grant_valid_d = 1'b0;
          rr_ptr_d      = nxt_ptr;
          stall_cnt_d   = '0;
          state_d       = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= IDLE;
      rr_ptr_q      <= '0;
      grant_idx_q   <= '0;
      grant_valid_q <= 1'b0;
      stall_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      grant_idx_q   <= grant_idx_d;
      grant_valid_q <= grant_valid_d;
      stall_cnt_q   <= stall_cnt_d;
    end
  end

  assign grant_valid = grant_valid_q;
  assign grant_idx   = grant_idx_q;

endmodule

// File: tb/tb_ingress_arbiter.sv
// Directed checks of grant gating/reset, then randomized traffic scored
// against a frame-level round-robin reference model.
module tb_ingress_arbiter;

  localparam int NP = 4;
  localparam int DW = 8;
  localparam int T  = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic [NP-1:0]     src_tvalid;
  logic [NP*DW-1:0]  src_tdata;
  logic [NP-1:0]     src_tlast;
  logic [NP-1:0]     src_tready;
  logic              out_tvalid;
  logic [DW-1:0]     out_tdata;
  logic              out_tlast;
  logic              out_tready;
  logic              almost_full;
  logic              grant_valid;
  logic [1:0]        grant_idx;
  logic              frame_abort;

  ingress_arbiter #(
    .NUM_PORTS(NP),
    .DATA_W(DW),
    .STALL_TIMEOUT(T)
  ) dut (
    .clk(clk),
    .reset(reset),
    .src_tvalid(src_tvalid),
    .src_tdata(src_tdata),
    .src_tlast(src_tlast),
    .src_tready(src_tready),
    .out_tvalid(out_tvalid),
    .out_tdata(out_tdata),
    .out_tlast(out_tlast),
    .out_tready(out_tready),
    .almost_full(almost_full),
    .grant_valid(grant_valid),
    .grant_idx(grant_idx),
    .frame_abort(frame_abort)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] d;
    bit            last;
    int            gap;
  } beat_t;

  typedef struct {
    logic [DW-1:0] d;
    bit            last;
    bit            abt;
    int            port;
  } exp_t;

  beat_t pq[NP][$];
  beat_t mq[NP][$];
  exp_t  sb[$];
  int    wcnt[NP];
  bit    abw[NP];
  int    checks = 0;
  int    errors = 0;
  bit    mon_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic nedge();
    @(negedge clk);
  endtask

  // Scoreboard monitor: pops one expected beat per accepted output beat.
  initial begin : mon
    exp_t e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        chk("tready_onehot", 32'($countones(src_tready) <= 1), 1);
        if (out_tvalid && out_tready) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_beat: data %0h with empty queue",
                     out_tdata);
          end else begin
            e = sb.pop_front();
            chk("beat",
                {grant_idx, out_tlast, frame_abort, out_tdata},
                {2'(e.port), e.last, e.abt, e.d});
          end
        end else begin
          chk("abort_idle", frame_abort, 0);
        end
      end
    end
  end

  task automatic drive();
    for (int p = 0; p < NP; p++) begin
      if (pq[p].size() > 0 && wcnt[p] == 0 && !abw[p]) begin
        src_tvalid[p]          = 1'b1;
        src_tdata[p*DW +: DW]  = pq[p][0].d;
        src_tlast[p]           = pq[p][0].last;
      end else begin
        src_tvalid[p]          = 1'b0;
        src_tdata[p*DW +: DW]  = DW'($urandom);
        src_tlast[p]           = 1'($urandom);
      end
    end
    out_tready  = ($urandom_range(0, 9) < 7);
    almost_full = ($urandom_range(0, 9) < 2);
  endtask

  // Reference: frame-level round robin over per-port beat lists; a gap of
  // T or more inside a frame ends it with an abort beat and the rest of
  // that frame becomes a new frame for the same port.
  task automatic build_model();
    int    ptr;
    int    p;
    bit    any;
    beat_t b;
    ptr = 0;
    for (int i = 0; i < NP; i++) mq[i] = pq[i];
    forever begin
      any = 1'b0;
      p = 0;
      for (int k = 0; k < NP; k++) begin
        if (!any && mq[(ptr + k) % NP].size() > 0) begin
          any = 1'b1;
          p = (ptr + k) % NP;
        end
      end
      if (!any) break;
      b = mq[p].pop_front();
      sb.push_back('{d: b.d, last: b.last, abt: 1'b0, port: p});
      while (!b.last) begin
        if (mq[p][0].gap >= T) begin
          sb.push_back('{d: '0, last: 1'b1, abt: 1'b1, port: p});
          mq[p][0].gap = 0;
          break;
        end
        b = mq[p].pop_front();
        sb.push_back('{d: b.d, last: b.last, abt: 1'b0, port: p});
      end
      ptr = (p + 1) % NP;
    end
  endtask

  initial begin
    bit    xf[NP];
    bit    ab[NP];
    bit    busy;
    int    cyc;
    int    nf;
    int    len;
    int    r;
    beat_t b;

    reset       = 1'b0;
    src_tvalid  = '0;
    src_tdata   = '0;
    src_tlast   = '0;
    out_tready  = 1'b1;
    almost_full = 1'b0;
    repeat (2) tick();
    nedge();
    chk("rst_grant_valid", grant_valid, 0);
    chk("rst_src_tready", src_tready, 0);
    chk("rst_out_tvalid", out_tvalid, 0);
    chk("rst_out_tlast", out_tlast, 0);
    chk("rst_frame_abort", frame_abort, 0);
    reset = 1'b1;

    // almost_full blocks new grants
    almost_full = 1'b1;
    src_tvalid  = 4'b0010;
    src_tlast   = 4'b1111;
    src_tdata   = {8'h44, 8'h33, 8'h22, 8'h11};
    for (int i = 0; i < 10; i++) begin
      tick();
      nedge();
      chk("af_block", grant_valid, 0);
    end
    almost_full = 1'b0;
    tick();
    nedge();
    chk("af_release_valid", grant_valid, 1);
    chk("af_release_idx", grant_idx, 1);
    chk("af_release_ready", src_tready, 4'b0010);
    chk("af_release_data", {out_tvalid, out_tlast, out_tdata}, 10'h322);
    almost_full = 1'b1;
    tick();
    nedge();
    chk("af_after_frame", grant_valid, 0);
    tick();
    nedge();
    chk("af_hold", grant_valid, 0);
    src_tvalid  = '0;
    almost_full = 1'b0;

    // rr_ptr is now 2: ports 0 and 2 request
    src_tvalid = 4'b0101;
    tick();
    nedge();
    chk("rr_first_idx", grant_idx, 2);
    chk("rr_first_valid", grant_valid, 1);
    tick();
    nedge();
    chk("rr_idle_gap", grant_valid, 0);
    tick();
    nedge();
    chk("rr_second_idx", grant_idx, 0);
    chk("rr_second_data", out_tdata, 8'h11);
    tick();
    src_tvalid = '0;

    // reset during BUSY, rr_ptr cleared
    src_tvalid = 4'b1000;
    src_tlast  = 4'b0000;
    tick();
    nedge();
    chk("pre_rst_idx", grant_idx, 3);
    chk("pre_rst_ready", src_tready, 4'b1000);
    reset = 1'b0;
    tick();
    reset      = 1'b1;
    src_tvalid = 4'b1001;
    nedge();
    chk("mid_rst_grant", grant_valid, 0);
    chk("mid_rst_ready", src_tready, 0);
    chk("mid_rst_tvalid", out_tvalid, 0);
    tick();
    nedge();
    chk("post_rst_rr", grant_idx, 0);
    reset      = 1'b0;
    src_tvalid = '0;
    tick();
    tick();

    // randomized traffic
    for (int p = 0; p < NP; p++) begin
      wcnt[p] = 0;
      abw[p]  = 1'b0;
      nf = $urandom_range(3, 6);
      for (int f = 0; f < nf; f++) begin
        len = $urandom_range(1, 5);
        for (int j = 0; j < len; j++) begin
          b.d    = DW'($urandom);
          b.last = (j == len - 1);
          b.gap  = 0;
          if (j > 0) begin
            r = $urandom_range(0, 9);
            if (r >= 9) b.gap = T + $urandom_range(0, 3);
            else if (r >= 6) b.gap = $urandom_range(1, T - 1);
          end
          pq[p].push_back(b);
        end
      end
    end
    build_model();
    drive();
    reset  = 1'b1;
    mon_en = 1'b1;
    cyc    = 0;
    busy   = 1'b1;
    while (busy && cyc < 20000) begin
      nedge();
      for (int p = 0; p < NP; p++) begin
        xf[p] = src_tvalid[p] && src_tready[p];
        ab[p] = frame_abort && (grant_idx == 2'(p));
      end
      tick();
      cyc++;
      for (int p = 0; p < NP; p++) begin
        if (xf[p]) begin
          b = pq[p].pop_front();
          if (!b.last && pq[p].size() > 0) begin
            if (pq[p][0].gap >= T) abw[p] = 1'b1;
            else wcnt[p] = pq[p][0].gap;
          end
        end else if (wcnt[p] > 0) begin
          wcnt[p]--;
        end
        if (ab[p]) abw[p] = 1'b0;
      end
      drive();
      busy = (sb.size() > 0);
      for (int p = 0; p < NP; p++) if (pq[p].size() > 0) busy = 1'b1;
    end
    nedge();
    mon_en = 1'b0;
    chk("drain_in_time", 32'(cyc < 20000), 1);
    chk("scoreboard_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
